arb_rr_reg: RTL and testbench
=============================

ARB_RR_REG -- requirements
Module: arb_rr_reg

Interface
REQ-001 Parameter WIDTH, default 32: number of requesters; SHALL be >= 2.
REQ-002 Parameter DIRECTION, default "LSB": "LSB" searches upward from bit 0, "MSB" searches downward from bit WIDTH-1.
REQ-003 Localparam WIDTH_LOG = $clog2(WIDTH): index width.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  WIDTH  level request vector, sampled every cycle.
REQ-007 gnt_vld  output  1  registered grant valid.
REQ-008 gnt_rdy  input  1  consumer accepts the grant.
REQ-009 gnt  output  WIDTH  registered one-hot grant.
REQ-010 gnt_idx  output  WIDTH_LOG  registered binary index of gnt; present only with ARB_RR_REG_IDX_EN.

Function
REQ-011 Handshake: transfer occurs on a rising edge with gnt_vld=1 and gnt_rdy=1.
REQ-012 Load condition: load = !gnt_vld || gnt_rdy; without load, gnt, gnt_idx and gnt_vld SHALL hold regardless of req.
REQ-013 On load: gnt_vld <= |req; gnt <= selected one-hot, or all-zero if req==0.
REQ-014 Latency: a request present at edge N SHALL produce gnt_vld=1 after edge N (1 cycle) when load is true.
REQ-015 Mask register: mask[WIDTH]; bits set mark requesters eligible in the masked (first-priority) search.
REQ-016 mask_nxt = mask without transfer; with transfer, mask_nxt = bits strictly after the granted bit in search direction ("LSB": above gnt; "MSB": below gnt).
REQ-017 Selection: sel = priority one-hot of (req & mask_nxt) if nonzero, else priority one-hot of req; priority is the first set bit in DIRECTION order.
REQ-018 mask SHALL load mask_nxt every cycle.
REQ-019 Wrap-around: granting the last bit in search order yields mask_nxt=0, so the next selection SHALL be from the unmasked req (bit 0 for "LSB", bit WIDTH-1 for "MSB").
REQ-020 Back-to-back: with gnt_rdy held 1, a new grant SHALL be issued every cycle; a just-granted requester SHALL be re-granted only if it is the sole requester.
REQ-021 Request drop while gnt_vld=1 and gnt_rdy=0: grant SHALL stay stable (no retraction).
REQ-022 gnt SHALL always be one-hot when gnt_vld=1 and all-zero when gnt_vld=0.
REQ-023 Fairness: with a constant req of K bits and gnt_rdy=1, each requester SHALL be granted exactly once per K consecutive transfers.

Reset
REQ-024 While rst=1, asynchronously: gnt_vld=0, gnt=0, gnt_idx=0, mask all-ones.
REQ-025 Reset asserted mid-transfer SHALL discard the pending grant; the first grant after release SHALL follow unmasked priority.
REQ-026 First load SHALL occur on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro ARB_RR_REG_IDX_EN defined: gnt_idx port and register exist, gnt_idx = binary position of the set bit in gnt, loaded and held together with gnt, 0 when gnt_vld=0.
REQ-028 Macro ARB_RR_REG_IDX_EN undefined: gnt_idx port and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8)
REQ-029 Reset released, req=8'h00 for 20 cycles -> gnt_vld=0, gnt=8'h00 throughout.
REQ-030 "LSB", req=8'b1010_0100 constant, gnt_rdy=1 -> gnt 8'h04, 8'h20, 8'h80, 8'h04 on consecutive cycles, first valid one cycle after req.
REQ-031 gnt=8'h04 valid, gnt_rdy=0 for 5 cycles while req drops to 8'h00 -> gnt_vld=1, gnt=8'h04 held until gnt_rdy=1, then gnt_vld=0.
REQ-032 req=8'h80 only, gnt_rdy=1 -> gnt=8'h80 every cycle (wrap, sole requester); with IDX_EN gnt_idx=7.
REQ-033 "MSB", req=8'h05, gnt_rdy=1 -> gnt 8'h04, 8'h01, 8'h04; with IDX_EN gnt_idx 2, 0, 2.
REQ-034 rst pulsed mid-cycle while gnt=8'h20 valid -> gnt_vld=0, gnt=8'h00 immediately; after release with req=8'h24, first gnt=8'h04 ("LSB").

Source files
------------

// File: rtl/arb_rr_reg.sv
// arb_rr_reg: registered round-robin arbiter with a valid/ready grant handshake.
// Define ARB_RR_REG_IDX_EN to add the registered binary grant index output gnt_idx.
module arb_rr_reg #(
    parameter int WIDTH     = 32,
    parameter     DIRECTION = "LSB",
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     req,
    output logic                 gnt_vld,
    input  logic                 gnt_rdy,
    output logic [WIDTH-1:0]     gnt
`ifdef ARB_RR_REG_IDX_EN
    ,
    output logic [WIDTH_LOG-1:0] gnt_idx
`endif
);

    localparam bit             DIR_LSB = (DIRECTION == "LSB");
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    // First set bit of v in search order, as a one-hot vector (zero if v is zero).
    function automatic logic [WIDTH-1:0] prio(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        logic             found;
        logic             hit;
        int               b;
        r     = {WIDTH{1'b0}};
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            b     = DIR_LSB ? i : (WIDTH - 1 - i);
            hit   = v[b] & ~found;
            r[b]  = hit;
            found = found | hit;
        end
        return r;
    endfunction

    // Requesters strictly after the one-hot grant g in search order.
    function automatic logic [WIDTH-1:0] after_mask(input logic [WIDTH-1:0] g);
        if (DIR_LSB) begin
            return ~(g | (g - ONE));
        end else begin
            return g - ONE;
        end
    endfunction

    logic                 gnt_vld_d, gnt_vld_q;
    logic [WIDTH-1:0]     gnt_d, gnt_q;
    logic [WIDTH-1:0]     mask_d, mask_q;
    logic                 xfer_s;
    logic                 load_s;
    logic [WIDTH-1:0]     masked_s;
    logic [WIDTH-1:0]     sel_s;

    // Mask update, selection and grant load/hold.
    always_comb begin
        xfer_s = gnt_vld_q & gnt_rdy;
        load_s = ~gnt_vld_q | gnt_rdy;
        if (xfer_s) begin
            mask_d = after_mask(gnt_q);
        end else begin
            mask_d = mask_q;
        end
        // Selection already sees the post-transfer mask so the winner is not re-granted.
        masked_s = req & mask_d;
        if (|masked_s) begin
            sel_s = prio(masked_s);
        end else begin
            sel_s = prio(req);
        end
        if (load_s) begin
            gnt_vld_d = |req;
            gnt_d     = sel_s;
        end else begin
            gnt_vld_d = gnt_vld_q;
            gnt_d     = gnt_q;
        end
    end

`ifdef ARB_RR_REG_IDX_EN
    logic [WIDTH_LOG-1:0] gnt_idx_d, gnt_idx_q;

    // Binary position of the set bit in a one-hot vector (zero if none).
    function automatic logic [WIDTH_LOG-1:0] idx_of(input logic [WIDTH-1:0] oh);
        logic [WIDTH_LOG-1:0] r;
        r = {WIDTH_LOG{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            r = r | (oh[i] ? i[WIDTH_LOG-1:0] : {WIDTH_LOG{1'b0}});
        end
        return r;
    endfunction

    // Index loads and holds together with the grant.
    always_comb begin
        if (load_s) begin
            gnt_idx_d = idx_of(sel_s);
        end else begin
            gnt_idx_d = gnt_idx_q;
        end
    end

    // State registers including the grant index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_vld_q <= 1'b0;
            gnt_q     <= {WIDTH{1'b0}};
            mask_q    <= {WIDTH{1'b1}};
            gnt_idx_q <= {WIDTH_LOG{1'b0}};
        end else begin
            gnt_vld_q <= gnt_vld_d;
            gnt_q     <= gnt_d;
            mask_q    <= mask_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

    assign gnt_idx = gnt_idx_q;
`else
    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_vld_q <= 1'b0;
            gnt_q     <= {WIDTH{1'b0}};
            mask_q    <= {WIDTH{1'b1}};
        end else begin
            gnt_vld_q <= gnt_vld_d;
            gnt_q     <= gnt_d;
            mask_q    <= mask_d;
        end
    end
`endif

    assign gnt_vld = gnt_vld_q;
    assign gnt     = gnt_q;

endmodule

// File: tb/tb_arb_rr_reg.sv
// Bench for arb_rr_reg: LSB and MSB instances share stimulus and are compared
// against a last-granted-position round-robin model.
module tb_arb_rr_reg;

    localparam int W  = 8;
    localparam int WL = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         gnt_rdy;
    logic [W-1:0] req;
    logic         vld_l, vld_m;
    logic [W-1:0] gnt_l, gnt_m;
`ifdef ARB_RR_REG_IDX_EN
    logic [WL-1:0] idx_l, idx_m;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Model state per direction (0 = LSB, 1 = MSB).
    bit           m_vld [2];
    logic [W-1:0] m_gnt [2];
    int           m_idx [2];
    int           m_last[2];

    always #5 clk = ~clk;

    arb_rr_reg #(.WIDTH(W), .DIRECTION("LSB")) u_lsb (
        .clk(clk), .rst(rst), .req(req), .gnt_vld(vld_l), .gnt_rdy(gnt_rdy), .gnt(gnt_l)
`ifdef ARB_RR_REG_IDX_EN
        , .gnt_idx(idx_l)
`endif
    );

    arb_rr_reg #(.WIDTH(W), .DIRECTION("MSB")) u_msb (
        .clk(clk), .rst(rst), .req(req), .gnt_vld(vld_m), .gnt_rdy(gnt_rdy), .gnt(gnt_m)
`ifdef ARB_RR_REG_IDX_EN
        , .gnt_idx(idx_m)
`endif
    );

    // Position of bit b in the search order of direction d (self-inverse).
    function automatic int ord(input int d, input int b);
        return (d == 0) ? b : (W - 1 - b);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_vld[d]  = 1'b0;
            m_gnt[d]  = '0;
            m_idx[d]  = 0;
            m_last[d] = -1;
        end
    endtask

    // One rising edge: remember who transferred, then pick the first requester
    // after that one in search order, wrapping to the start if there is none.
    task automatic model_clock(input logic [W-1:0] r, input logic rdy);
        int pick;
        for (int d = 0; d < 2; d++) begin
            if (m_vld[d] && rdy) m_last[d] = ord(d, m_idx[d]);
            if (!m_vld[d] || rdy) begin
                pick = -1;
                for (int k = m_last[d] + 1; k < W; k++)
                    if (pick < 0 && r[ord(d, k)]) pick = k;
                for (int k = 0; k < W; k++)
                    if (pick < 0 && r[ord(d, k)]) pick = k;
                m_vld[d] = (pick >= 0);
                m_gnt[d] = '0;
                m_idx[d] = 0;
                if (pick >= 0) begin
                    m_idx[d] = ord(d, pick);
                    m_gnt[d][m_idx[d]] = 1'b1;
                end
            end
        end
    endtask

    task automatic check(input string tag);
        vectors++;
        assert (vld_l === m_vld[0]) else begin
            miscompares++;
            $error("FAIL %s lsb_vld: observed %0b expected %0b", tag, vld_l, m_vld[0]);
        end
        assert (gnt_l === m_gnt[0]) else begin
            miscompares++;
            $error("FAIL %s lsb_gnt: observed %h expected %h", tag, gnt_l, m_gnt[0]);
        end
        assert (vld_m === m_vld[1]) else begin
            miscompares++;
            $error("FAIL %s msb_vld: observed %0b expected %0b", tag, vld_m, m_vld[1]);
        end
        assert (gnt_m === m_gnt[1]) else begin
            miscompares++;
            $error("FAIL %s msb_gnt: observed %h expected %h", tag, gnt_m, m_gnt[1]);
        end
`ifdef ARB_RR_REG_IDX_EN
        assert (idx_l === WL'(m_idx[0])) else begin
            miscompares++;
            $error("FAIL %s lsb_idx: observed %0d expected %0d", tag, idx_l, m_idx[0]);
        end
        assert (idx_m === WL'(m_idx[1])) else begin
            miscompares++;
            $error("FAIL %s msb_idx: observed %0d expected %0d", tag, idx_m, m_idx[1]);
        end
`endif
    endtask

    // Fixed expectations written out directly from the scenario descriptions.
    task automatic expect_l(input string tag, input logic v, input logic [W-1:0] g);
        vectors++;
        assert (vld_l === v && gnt_l === g) else begin
            miscompares++;
            $error("FAIL %s: observed vld=%0b gnt=%h expected vld=%0b gnt=%h", tag, vld_l, gnt_l, v, g);
        end
    endtask

    task automatic expect_m(input string tag, input logic v, input logic [W-1:0] g);
        vectors++;
        assert (vld_m === v && gnt_m === g) else begin
            miscompares++;
            $error("FAIL %s: observed vld=%0b gnt=%h expected vld=%0b gnt=%h", tag, vld_m, gnt_m, v, g);
        end
    endtask

    // Called at a falling edge: apply inputs, step the model on the rising edge, check.
    task automatic step(input logic [W-1:0] r, input logic rdy, input string tag);
        req     = r;
        gnt_rdy = rdy;
        @(posedge clk);
        model_clock(r, rdy);
        @(negedge clk);
        check(tag);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_async");
        expect_l("rst_async_lsb", 1'b0, 8'h00);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rv;
        rst     = 1'b1;
        req     = 8'h00;
        gnt_rdy = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset");
        expect_l("reset_lsb", 1'b0, 8'h00);
        rst = 1'b0;

        for (int n = 0; n < 20; n++) begin
            step(8'h00, 1'b1, "idle");
            expect_l("idle_lsb", 1'b0, 8'h00);
        end

        step(8'hA4, 1'b1, "rr_a4");
        expect_l("rr_a4_0", 1'b1, 8'h04);
        expect_m("rr_a4_m0", 1'b1, 8'h80);
        step(8'hA4, 1'b1, "rr_a4");
        expect_l("rr_a4_1", 1'b1, 8'h20);
        step(8'hA4, 1'b1, "rr_a4");
        expect_l("rr_a4_2", 1'b1, 8'h80);
        step(8'hA4, 1'b1, "rr_a4");
        expect_l("rr_a4_3", 1'b1, 8'h04);

        for (int n = 0; n < 5; n++) begin
            step(8'h00, 1'b0, "stall_drop");
            expect_l("stall_hold", 1'b1, 8'h04);
        end
        step(8'h00, 1'b1, "stall_release");
        expect_l("stall_release", 1'b0, 8'h00);

        for (int n = 0; n < 4; n++) begin
            step(8'h80, 1'b1, "sole_80");
            expect_l("sole_80", 1'b1, 8'h80);
`ifdef ARB_RR_REG_IDX_EN
            vectors++;
            assert (idx_l === 3'd7) else begin
                miscompares++;
                $error("FAIL sole_80_idx: observed %0d expected 7", idx_l);
            end
`endif
        end

        step(8'h05, 1'b1, "msb_05");
        expect_m("msb_05_0", 1'b1, 8'h04);
        step(8'h05, 1'b1, "msb_05");
        expect_m("msb_05_1", 1'b1, 8'h01);
        step(8'h05, 1'b1, "msb_05");
        expect_m("msb_05_2", 1'b1, 8'h04);
`ifdef ARB_RR_REG_IDX_EN
        vectors++;
        assert (idx_m === 3'd2) else begin
            miscompares++;
            $error("FAIL msb_05_idx: observed %0d expected 2", idx_m);
        end
`endif

        pulse_reset();
        step(8'h20, 1'b0, "pre_rst");
        expect_l("pre_rst", 1'b1, 8'h20);
        pulse_reset();
        step(8'h24, 1'b1, "post_rst");
        expect_l("post_rst", 1'b1, 8'h04);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) pulse_reset();
            if ((n / 40) % 3 == 1) begin
                if (n % 40 == 0) rv = W'($urandom);
            end else begin
                case ($urandom_range(0, 3))
                    0:       rv = 8'h00;
                    1:       rv = 8'h01 << $urandom_range(0, W - 1);
                    default: rv = W'($urandom);
                endcase
            end
            step(rv, ($urandom_range(0, 3) != 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
